mac32_acc_drain: RTL and testbench

Readout end of the 32-lane MAC accumulator array. On command, it snapshots the full accumulator vector, pulses a clear back to the accumulator core, and requantizes each 32-bit lane to int8 with rounding shift and saturation. It then streams the lanes out as valid/ready beats to the activation write-back path. The snapshot lets the core start the next tile while the previous tile is still draining.

---
 rtl/mac32_pkg.sv | 28 ++
 rtl/mac32_requant_lane.sv | 60 ++++++
 rtl/mac32_acc_drain.sv | 148 ++++++++++++++
 tb/tb_mac32_acc_drain.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac32_pkg.sv
// mac32_pkg: shared definitions for the MAC accumulator drain path.
//   - default array geometry (lanes, widths, lanes per beat) and beat count
//   - drain FSM state encoding
//   - int8 saturation bounds
//   - counter width helper
package mac32_pkg;

    localparam int unsigned DEF_LANES = 32;
    localparam int unsigned DEF_ACC_W = 32;
    localparam int unsigned DEF_OUT_W = 8;
    localparam int unsigned DEF_LPB   = 4;
    localparam int unsigned DEF_BEATS = DEF_LANES / DEF_LPB;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } drain_state_e;

    // Beat counter width; never zero even for a single-beat configuration.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mac32_requant_lane.sv
// mac32_requant_lane: combinational requantizer for one accumulator lane.
// Rounds half up while shifting right, saturates to the signed output range
// and, when built with MAC_DRAIN_RELU_EN, clamps negatives to zero.
//   x        in  ACC_W  signed accumulator value
//   shift    in  5      right-shift amount 0..31
//   relu_en  in  1      clamp negatives (only honoured with MAC_DRAIN_RELU_EN)
//   y        out OUT_W  signed requantized element
module mac32_requant_lane
    import mac32_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic [ACC_W-1:0] x,
    input  logic [4:0]       shift,
    input  logic             relu_en,
    output logic [OUT_W-1:0] y
);

    localparam logic signed [ACC_W:0] MAX_V   = (ACC_W + 1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] MIN_V   = (ACC_W + 1)'(OUT_MIN);
    localparam logic [ACC_W:0]        RND_ONE = (ACC_W + 1)'(1);
    localparam logic [OUT_W-1:0]      MAX_Q   = OUT_W'(OUT_MAX);
    localparam logic [OUT_W-1:0]      MIN_Q   = OUT_W'(OUT_MIN);

    // One extra bit so x + 2^(shift-1) cannot wrap for large positive x.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] y_full;

    always_comb begin
        ext = {x[ACC_W-1], x};
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = RND_ONE << (shift - 5'd1);
        end
        sum    = ext + rnd;
        y_full = sum >>> shift;

        if (y_full > MAX_V) begin
            y = MAX_Q;
        end else if (y_full < MIN_V) begin
            y = MIN_Q;
        end else begin
            y = y_full[OUT_W-1:0];
        end
`ifdef MAC_DRAIN_RELU_EN
        if (relu_en && y_full[ACC_W]) begin
            y = '0;
        end
`endif
    end

`ifndef MAC_DRAIN_RELU_EN
    logic unused_relu_en;
    assign unused_relu_en = relu_en;
`endif

endmodule

// File: rtl/mac32_acc_drain.sv
// mac32_acc_drain: readout end of the 32-lane MAC accumulator array.
// On drain_start (in idle) the accumulator vector and requant config are
// snapshotted, a one-cycle clear is sent back to the core, and the lanes are
// streamed out LPB at a time as requantized int8 valid/ready beats.
// Optional feature macro: MAC_DRAIN_RELU_EN (compiles in the ReLU clamp).
//   CLK, RESETn      clock, synchronous active-low reset
//   acc_in           LANES*ACC_W accumulator vector, lane i at [i*ACC_W +: ACC_W]
//   drain_start      request snapshot + drain (idle only, not queued)
//   shift, relu_en   requant config, sampled with drain_start
//   acc_clear_o      one-cycle clear pulse to the core
//   drain_busy       high while beats are being streamed
//   drain_done       one-cycle pulse after the final handshake
//   out_valid/ready  beat handshake
//   out_data         LPB*OUT_W beat, element j = lane (beat*LPB + j)
//   out_last         marks the final beat
module mac32_acc_drain
    import mac32_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned LPB   = DEF_LPB
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [LANES*ACC_W-1:0] acc_in,
    input  logic                   drain_start,
    input  logic [4:0]             shift,
    input  logic                   relu_en,
    output logic                   acc_clear_o,
    output logic                   drain_busy,
    output logic                   drain_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LPB*OUT_W-1:0]   out_data,
    output logic                   out_last
);

    localparam int unsigned BEATS  = LANES / LPB;
    localparam int unsigned CNT_W  = cnt_width(BEATS);
    localparam int unsigned BEAT_W = LPB * ACC_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    drain_state_e state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clear_q;
    logic                   accept;
    logic [LANES*ACC_W-1:0] snap_q;
    logic [4:0]             cfg_shift_q;
    logic                   lane_relu;

    logic [BEAT_W-1:0]    beat_vec [BEATS];
    logic [BEAT_W-1:0]    beat_sel;
    logic [LPB*OUT_W-1:0] beat_req;

`ifdef MAC_DRAIN_RELU_EN
    logic cfg_relu_q;
    assign lane_relu = cfg_relu_q;
`else
    logic unused_relu_en;
    assign unused_relu_en = relu_en;
    assign lane_relu      = 1'b0;
`endif

    // Beat selection works only off registered snapshot/count/config, so
    // out_data has no combinational dependence on out_ready.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_vec[b] = snap_q[b*BEAT_W +: BEAT_W];
    end
    assign beat_sel = beat_vec[cnt_q];

    for (genvar j = 0; j < LPB; j++) begin : g_lane
        mac32_requant_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .x       (beat_sel[j*ACC_W +: ACC_W]),
            .shift   (cfg_shift_q),
            .relu_en (lane_relu),
            .y       (beat_req[j*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        drain_busy = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (drain_start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                out_valid  = 1'b1;
                drain_busy = 1'b1;
                out_data   = beat_req;
                out_last   = (cnt_q == LAST_BEAT);
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                drain_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            clear_q     <= 1'b0;
            snap_q      <= '0;
            cfg_shift_q <= '0;
`ifdef MAC_DRAIN_RELU_EN
            cfg_relu_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= accept;
            if (accept) begin
                snap_q      <= acc_in;
                cfg_shift_q <= shift;
`ifdef MAC_DRAIN_RELU_EN
                cfg_relu_q  <= relu_en;
`endif
            end
        end
    end

    assign acc_clear_o = clear_q;

endmodule

// File: tb/tb_mac32_acc_drain.sv
// tb_mac32_acc_drain: directed self-checking bench for mac32_acc_drain.
// Covers reset values, streaming order/timing, rounding, saturation, ReLU
// build option, backpressure, ignored restarts and mid-stream reset.
module tb_mac32_acc_drain;
    import mac32_pkg::*;

    localparam int unsigned LANES = DEF_LANES;
    localparam int unsigned ACC_W = DEF_ACC_W;

    logic                   CLK = 1'b0;
    logic                   RESETn;
    logic [LANES*ACC_W-1:0] acc_in;
    logic                   drain_start;
    logic [4:0]             shift;
    logic                   relu_en;
    logic                   acc_clear_o;
    logic                   drain_busy;
    logic                   drain_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_data;
    logic                   out_last;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mac32_acc_drain u_dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .acc_in      (acc_in),
        .drain_start (drain_start),
        .shift       (shift),
        .relu_en     (relu_en),
        .acc_clear_o (acc_clear_o),
        .drain_busy  (drain_busy),
        .drain_done  (drain_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lanes(input int off);
        for (int i = 0; i < int'(LANES); i++) begin
            acc_in[i*ACC_W +: ACC_W] = 32'(off + i);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] val);
        acc_in[i*ACC_W +: ACC_W] = val;
    endtask

    // Returns in the first cycle after the accepting edge.
    task automatic start(input logic [4:0] s, input logic r);
        drain_start = 1'b1;
        shift       = s;
        relu_en     = r;
        step();
        drain_start = 1'b0;
    endtask

    task automatic finish_drain();
        int n = 0;
        out_ready = 1'b1;
        while (!drain_done && n < 20) begin
            step();
            n++;
        end
        check("drain_done_seen", 32'(drain_done), 32'd1);
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_clear"}, 32'(acc_clear_o), 32'd0);
        check({tag, "_busy"},  32'(drain_busy),  32'd0);
        check({tag, "_done"},  32'(drain_done),  32'd0);
        check({tag, "_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_data"},  out_data,         32'd0);
        check({tag, "_last"},  32'(out_last),    32'd0);
    endtask

    function automatic logic [31:0] exp_beat(input int k, input int off);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[j*8 +: 8] = 8'(off + 4*k + j);
        end
        return r;
    endfunction

    initial begin
        logic [31:0] exp_relu;
        logic        pat [4];
        int          k;
        int          cyc;

        RESETn      = 1'b0;
        drain_start = 1'b0;
        shift       = '0;
        relu_en     = 1'b0;
        out_ready   = 1'b1;
        acc_in      = '0;
        step();
        step();
        check_idle_outputs("reset");
        RESETn = 1'b1;
        step();

        // Lanes = index, shift 0: plain ordered stream and cycle timing.
        set_lanes(0);
        start(5'd0, 1'b0);
        check("t1_clear_pulse", 32'(acc_clear_o), 32'd1);
        check("t1_busy", 32'(drain_busy), 32'd1);
        for (int b = 0; b < 8; b++) begin
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data", out_data, exp_beat(b, 0));
            check("t1_last", 32'(out_last), 32'(b == 7));
            check("t1_done_early", 32'(drain_done), 32'd0);
            if (b > 0) check("t1_clear_once", 32'(acc_clear_o), 32'd0);
            step();
        end
        check("t1_done", 32'(drain_done), 32'd1);
        check("t1_busy_off", 32'(drain_busy), 32'd0);
        check("t1_valid_off", 32'(out_valid), 32'd0);
        step();
        check("t1_done_pulse", 32'(drain_done), 32'd0);

        // Round half up: 1.5 -> 2, -1.5 -> -1.
        acc_in = '0;
        set_lane(0, 32'h0000_0180);
        set_lane(1, 32'hFFFF_FE80);
        start(5'd8, 1'b0);
        check("round_half_up", out_data, 32'h0000_FF02);
        finish_drain();

        // Saturation at shift 0, plus exact bounds.
        acc_in = '0;
        set_lane(0, 32'(100000));
        set_lane(1, 32'(-100000));
        set_lane(2, 32'(-128));
        set_lane(3, 32'(127));
        start(5'd0, 1'b0);
        check("saturate", out_data, 32'h7F80_807F);
        finish_drain();

        // Shift 31 extremes: rounding add must not wrap.
        acc_in = '0;
        set_lane(0, 32'h8000_0000);
        set_lane(1, 32'h0000_0000);
        set_lane(2, 32'h7FFF_FFFF);
        set_lane(3, 32'hFFFF_FFFF);
        start(5'd31, 1'b0);
        check("shift31", out_data, 32'h0001_00FF);
        finish_drain();

        // ReLU request: honoured only in the ReLU build.
        acc_in = '0;
        set_lane(0, 32'(-50));
        set_lane(1, 32'(60));
        set_lane(2, 32'(-100000));
`ifdef MAC_DRAIN_RELU_EN
        exp_relu = 32'h0000_3C00;
`else
        exp_relu = 32'h0080_3CCE;
`endif
        start(5'd0, 1'b1);
        check("relu", out_data, exp_relu);
        finish_drain();

        // Backpressure with ready pattern 1,0,0,1; a restart mid-stream is ignored.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_lanes(0);
        start(5'd0, 1'b0);
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            out_ready   = pat[cyc % 4];
            drain_start = (cyc == 3);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, exp_beat(k, 0));
            check("bp_last", 32'(out_last), 32'(k == 7));
            if (out_ready) k++;
            step();
            cyc++;
        end
        drain_start = 1'b0;
        out_ready   = 1'b1;
        check("bp_complete", 32'(k), 32'd8);
        check("bp_done", 32'(drain_done), 32'd1);
        step();
        check("bp_no_restart_valid", 32'(out_valid), 32'd0);
        step();
        check("bp_no_restart_valid2", 32'(out_valid), 32'd0);
        check("bp_no_restart_done", 32'(drain_done), 32'd0);

        // Reset while beat 3 is presented abandons the transfer.
        set_lanes(0);
        start(5'd0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            check("rst_pre_data", out_data, exp_beat(b, 0));
            if (b < 3) step();
        end
        RESETn = 1'b0;
        step();
        RESETn = 1'b1;
        check_idle_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_done", 32'(drain_done), 32'd0);
            check("rst_no_valid", 32'(out_valid), 32'd0);
        end

        // Fresh snapshot drains from beat 0.
        set_lanes(64);
        start(5'd0, 1'b0);
        check("rst_new_clear", 32'(acc_clear_o), 32'd1);
        for (int b = 0; b < 8; b++) begin
            check("rst_new_data", out_data, exp_beat(b, 64));
            step();
        end
        check("rst_new_done", 32'(drain_done), 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
